// File: rtl/spectrum_peak_tracker_pkg.sv
// Shared FFT post-processing types: converter default widths, peak record, tracker states.
// Pure declarations; no logic, no latency, no flow control.
package spectrum_peak_tracker_pkg;

    localparam int MAG_W_DEF   = 32;
    localparam int PHASE_W_DEF = 32;
    localparam int N_BINS_DEF  = 16;
    localparam int IDX_W_DEF   = $clog2(N_BINS_DEF);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_REPORT  = 2'd2
    } trk_state_e;

    typedef struct packed {
        logic        [IDX_W_DEF-1:0]   idx;
        logic signed [MAG_W_DEF-1:0]   mag;
        logic        [PHASE_W_DEF-1:0] phase;
    } peak_rec_t;

endpackage

// File: rtl/spectrum_peak_tracker_peak_compare_reg.sv
// Running-maximum record register: load unconditionally, or replace only on strictly greater magnitude.
// o_max_nxt is the post-edge value (combinational); register updates one edge later; always ready.
module peak_compare_reg
    import spectrum_peak_tracker_pkg::*;
#(
    parameter type rec_t = peak_rec_t
) (
    input  logic clk,
    input  logic arstn,
    input  logic i_load,
    input  logic i_update,
    input  logic i_clear,
    input  rec_t i_rec,
    output rec_t o_max_nxt
);

    rec_t r_max;
    logic w_gt;

    // Strict compare keeps the earliest bin on ties.
    assign w_gt = $signed(i_rec.mag) > $signed(r_max.mag);

    always_comb begin
        o_max_nxt = r_max;
        if (i_load) begin
            o_max_nxt = i_rec;
        end else if (i_update && w_gt) begin
            o_max_nxt = i_rec;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_max <= '0;
        end else if (i_load || i_update) begin
            r_max <= o_max_nxt;
        end else if (i_clear) begin
            r_max <= '0;
        end
    end

endmodule

// File: rtl/spectrum_peak_tracker.sv
// Per-frame peak search and magnitude sum over converter results; report pulse one cycle after last bin.
// No backpressure: one bin accepted on every i_vld cycle, including the report cycle.
module spectrum_peak_tracker
    import spectrum_peak_tracker_pkg::*;
#(
    parameter int N_BINS  = N_BINS_DEF,
    parameter int MAG_W   = MAG_W_DEF,
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int IDX_W   = $clog2(N_BINS),
    parameter int SUM_W   = MAG_W + $clog2(N_BINS)
) (
    input  logic               clk,
    input  logic               arstn,
    input  logic               i_frame_start,
    input  logic               i_vld,
    input  logic [MAG_W-1:0]   i_mag,
    input  logic [PHASE_W-1:0] i_phase,
    input  logic [MAG_W-1:0]   i_thresh,
    output logic               o_vld,
    output logic [IDX_W-1:0]   o_peak_idx,
    output logic [MAG_W-1:0]   o_peak_mag,
    output logic [PHASE_W-1:0] o_peak_phase,
    output logic [SUM_W-1:0]   o_mag_sum,
    output logic               o_detect,
    output logic               o_busy
);

    typedef struct packed {
        logic        [IDX_W-1:0]   idx;
        logic signed [MAG_W-1:0]   mag;
        logic        [PHASE_W-1:0] phase;
    } rec_t;

    trk_state_e r_state;
    trk_state_e w_state_nxt;

    logic [IDX_W-1:0] r_cnt;
    logic [SUM_W-1:0] r_sum;
    rec_t             r_peak;
    logic [SUM_W-1:0] r_sum_out;
    logic             r_detect;

    logic             w_bin0;
    logic             w_last;
    logic [IDX_W-1:0] w_idx;
    logic [SUM_W-1:0] w_mag_ext;
    logic [SUM_W-1:0] w_sum_nxt;
    rec_t             w_rec_in;
    rec_t             w_max_nxt;

    // A frame start always makes the current sample bin 0 and suppresses the report.
    assign w_bin0    = i_frame_start || (r_cnt == '0);
    assign w_last    = i_vld && !i_frame_start && (r_cnt == IDX_W'(N_BINS - 1));
    assign w_idx     = w_bin0 ? '0 : r_cnt;
    assign w_mag_ext = {{(SUM_W - MAG_W){i_mag[MAG_W-1]}}, i_mag};
    assign w_sum_nxt = w_bin0 ? w_mag_ext : (r_sum + w_mag_ext);

    always_comb begin
        w_rec_in       = '0;
        w_rec_in.idx   = w_idx;
        w_rec_in.mag   = i_mag;
        w_rec_in.phase = i_phase;
    end

    peak_compare_reg #(
        .rec_t (rec_t)
    ) u_max (
        .clk       (clk),
        .arstn     (arstn),
        .i_load    (i_vld && w_bin0),
        .i_update  (i_vld && !w_bin0),
        .i_clear   (i_frame_start && !i_vld),
        .i_rec     (w_rec_in),
        .o_max_nxt (w_max_nxt)
    );

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_cnt <= '0;
            r_sum <= '0;
        end else if (i_vld) begin
            r_cnt <= w_last ? '0 : (w_idx + 1'b1);
            r_sum <= w_sum_nxt;
        end else if (i_frame_start) begin
            r_cnt <= '0;
            r_sum <= '0;
        end
    end

    // Final max/sum are taken from the next-state values so the report lands one cycle after the last bin.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_peak    <= '0;
            r_sum_out <= '0;
            r_detect  <= 1'b0;
        end else if (w_last) begin
            r_peak    <= w_max_nxt;
            r_sum_out <= w_sum_nxt;
            r_detect  <= $signed(w_max_nxt.mag) >= $signed(i_thresh);
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_vld) begin
                    w_state_nxt = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (w_last) begin
                    w_state_nxt = ST_REPORT;
                end else if (i_frame_start && !i_vld) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REPORT: begin
                w_state_nxt = i_vld ? ST_COLLECT : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_vld        = (r_state == ST_REPORT);
    assign o_busy       = (r_state == ST_COLLECT);
    assign o_peak_idx   = r_peak.idx;
    assign o_peak_mag   = r_peak.mag;
    assign o_peak_phase = r_peak.phase;
    assign o_mag_sum    = r_sum_out;
    assign o_detect     = r_detect;

endmodule

// File: tb/tb_spectrum_peak_tracker.sv
// Directed bench for spectrum_peak_tracker with an 8-bin frame.
module tb_spectrum_peak_tracker;

    localparam int N_BINS  = 8;
    localparam int MAG_W   = 32;
    localparam int PHASE_W = 32;
    localparam int IDX_W   = 3;
    localparam int SUM_W   = 35;

    logic               clk;
    logic               arstn;
    logic               i_frame_start;
    logic               i_vld;
    logic [MAG_W-1:0]   i_mag;
    logic [PHASE_W-1:0] i_phase;
    logic [MAG_W-1:0]   i_thresh;
    logic               o_vld;
    logic [IDX_W-1:0]   o_peak_idx;
    logic [MAG_W-1:0]   o_peak_mag;
    logic [PHASE_W-1:0] o_peak_phase;
    logic [SUM_W-1:0]   o_mag_sum;
    logic               o_detect;
    logic               o_busy;

    int checks;
    int errors;
    int vld_pulses;
    int f1_mag [8];

    spectrum_peak_tracker #(
        .N_BINS  (N_BINS),
        .MAG_W   (MAG_W),
        .PHASE_W (PHASE_W),
        .IDX_W   (IDX_W),
        .SUM_W   (SUM_W)
    ) dut (
        .clk           (clk),
        .arstn         (arstn),
        .i_frame_start (i_frame_start),
        .i_vld         (i_vld),
        .i_mag         (i_mag),
        .i_phase       (i_phase),
        .i_thresh      (i_thresh),
        .o_vld         (o_vld),
        .o_peak_idx    (o_peak_idx),
        .o_peak_mag    (o_peak_mag),
        .o_peak_phase  (o_peak_phase),
        .o_mag_sum     (o_mag_sum),
        .o_detect      (o_detect),
        .o_busy        (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_report(input string tag, input int idx, input int mag, input int ph,
                              input int sum);
        chk({tag, ".vld"},   longint'(o_vld), 64'sd1);
        chk({tag, ".idx"},   longint'(o_peak_idx), longint'(idx));
        chk({tag, ".mag"},   longint'($signed(o_peak_mag)), longint'(mag));
        chk({tag, ".phase"}, longint'($signed(o_peak_phase)), longint'(ph));
        chk({tag, ".sum"},   longint'($signed(o_mag_sum)), longint'(sum));
    endtask

    task automatic send_bin(input int mag, input int ph, input bit fs);
        i_vld         = 1'b1;
        i_frame_start = fs;
        i_mag         = mag;
        i_phase       = ph;
        @(posedge clk);
        #1;
        i_vld         = 1'b0;
        i_frame_start = 1'b0;
        vld_pulses += int'(o_vld);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            vld_pulses += int'(o_vld);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        vld_pulses    = 0;
        f1_mag        = '{10, 50, 20, 80, 30, 80, 5, 1};
        arstn         = 1'b0;
        i_frame_start = 1'b0;
        i_vld         = 1'b0;
        i_mag         = '0;
        i_phase       = '0;
        i_thresh      = 81;

        #12;
        chk("rst.vld",  longint'(o_vld), 64'sd0);
        chk("rst.busy", longint'(o_busy), 64'sd0);
        chk("rst.sum",  longint'(o_mag_sum), 64'sd0);
        @(negedge clk);
        arstn = 1'b1;
        idle(2);

        // Frame 1, threshold 81: peak 80 at bin 3, tie at bin 5 ignored.
        for (int b = 0; b < 8; b++) begin
            send_bin(f1_mag[b], 100 * b, 1'b0);
            if (b == 2) chk("f1.busy", longint'(o_busy), 64'sd1);
            if (b == 6) chk("f1.novld_early", longint'(o_vld), 64'sd0);
        end
        chk_report("f1", 3, 80, 300, 276);
        chk("f1.detect81", longint'(o_detect), 64'sd0);
        idle(1);
        chk("f1.vld_one_cycle", longint'(o_vld), 64'sd0);
        chk("f1.idle_busy", longint'(o_busy), 64'sd0);
        chk("f1.hold_mag", longint'($signed(o_peak_mag)), 64'sd80);
        idle(1);

        // Same frame at threshold 80, then frame 2 (all 7) with no gap.
        i_thresh = 80;
        for (int b = 0; b < 8; b++) send_bin(f1_mag[b], 100 * b, 1'b0);
        chk_report("f1b", 3, 80, 300, 276);
        chk("f1b.detect80", longint'(o_detect), 64'sd1);
        for (int b = 0; b < 8; b++) begin
            send_bin(7, 100 * b, 1'b0);
            if (b == 0) chk("b2b.busy_after_report", longint'(o_busy), 64'sd1);
            if (b == 4) begin
                chk("b2b.hold_idx", longint'(o_peak_idx), 64'sd3);
                chk("b2b.hold_sum", longint'($signed(o_mag_sum)), 64'sd276);
            end
        end
        chk_report("f2", 0, 7, 0, 56);
        chk("f2.detect", longint'(o_detect), 64'sd0);
        idle(2);

        // Abort after 5 bins; restart carries mag 9 as bin 0.
        vld_pulses = 0;
        for (int b = 0; b < 5; b++) send_bin(3, 0, 1'b0);
        send_bin(9, 900, 1'b1);
        for (int b = 0; b < 7; b++) send_bin(1, 0, 1'b0);
        chk_report("abort", 0, 9, 900, 16);
        idle(1);
        chk("abort.one_report", longint'(vld_pulses), 64'sd1);

        // Frame start coinciding with the last bin wins: that sample becomes bin 0.
        vld_pulses = 0;
        for (int b = 0; b < 7; b++) send_bin(3, 0, 1'b0);
        send_bin(2, 20, 1'b1);
        chk("coinc.no_report", longint'(o_vld), 64'sd0);
        for (int b = 1; b < 8; b++) send_bin(4, 10 * b, 1'b0);
        chk_report("coinc", 1, 4, 10, 30);
        idle(1);
        chk("coinc.one_report", longint'(vld_pulses), 64'sd1);

        // Reset mid-frame clears everything; next frame starts at bin 0.
        for (int b = 0; b < 3; b++) send_bin(50, 0, 1'b0);
        arstn = 1'b0;
        #1;
        chk("arst.idx",  longint'(o_peak_idx), 64'sd0);
        chk("arst.mag",  longint'(o_peak_mag), 64'sd0);
        chk("arst.sum",  longint'(o_mag_sum), 64'sd0);
        chk("arst.busy", longint'(o_busy), 64'sd0);
        chk("arst.det",  longint'(o_detect), 64'sd0);
        idle(2);
        @(negedge clk);
        arstn = 1'b1;
        idle(1);
        for (int b = 0; b < 8; b++) send_bin(b + 1, 100 * b, 1'b0);
        chk_report("post_rst", 7, 8, 700, 36);
        idle(2);

        // Sparse negative frame, one bin every 18 cycles.
        i_thresh = -3;
        for (int b = 0; b < 8; b++) begin
            send_bin((b == 6) ? -2 : -5, 100 * b, 1'b0);
            if (b == 7) begin
                chk_report("neg", 6, -2, 600, -37);
                chk("neg.detect", longint'(o_detect), 64'sd1);
            end else begin
                idle(17);
                if (b == 3) chk("neg.busy_gap", longint'(o_busy), 64'sd1);
            end
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
